seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Parametrised sequential shift-add multiplier: the next generation of the team's 4x4 combinational array multiplier. It trades area for latency, adds signed (two's-complement) operation and uses a start/done handshake. It sits on the datapath as a multi-cycle arithmetic unit driven by a controlling FSM or testbench. Default width matches the existing 4-bit multiplier, so the 4x4 regression vectors are reusable.

## Interface
Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk when ready.
- signed_mode  input  1  1 = operands and product are two's complement; 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while a multiplication is in progress (CALC state).
- done  output  1  one-cycle pulse; product valid.
- product  output  2*WIDTH  result; held until the next result is written.

## Operation
- States:
  - IDLE: ready.
  - CALC: iterating; an internal counter counts WIDTH cycles.
  - DONE: done=1 for exactly one cycle.
- Transitions:
  - IDLE --start--> CALC.
  - CALC --count==WIDTH-1--> DONE.
  - DONE --start--> CALC; otherwise DONE -> IDLE.
- Accept: start is accepted in IDLE or DONE only. start while busy=1 is ignored; operands are not re-sampled.
- On accept:
  - Latch the sign flag: signed_mode & (a[MSB] ^ b[MSB]).
  - Latch the magnitudes: |a| and |b| in WIDTH-bit unsigned form when signed_mode=1 (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned); raw a and b otherwise.
  - Clear the 2*WIDTH accumulator.
- Each CALC cycle:
  - If multiplier LSB=1, add the shifted multiplicand to the accumulator.
  - Shift the multiplicand left by 1 and the multiplier right by 1.
  - Increment the counter.
- Entry to DONE: product <= sign flag ? -accumulator : accumulator, modulo 2^(2*WIDTH).
- Result range:
  - The signed result always fits 2*WIDTH bits. Max is (-2^(W-1))^2 = 2^(2W-2).
  - The unsigned result always fits; no overflow flag.
- product changes only on entry to DONE. It is stable in IDLE, CALC and DONE until then, so the previous result stays readable during a new operation.
- Reset (asynchronous, any state, including mid-CALC): the operation is aborted.
  - State = IDLE.
  - busy=0, done=0, product=0.
  - Accumulator, counter and operand registers = 0.
  - No done pulse for the aborted operation.
- Input changes on a, b or signed_mode after acceptance have no effect on the running operation.

## Timing
- Latency:
  - start sampled high at edge k.
  - busy=1 after edge k through edge k+WIDTH.
  - done=1 and product valid after edge k+WIDTH+1, for one cycle.
  - Total latency: WIDTH+1 cycles; WIDTH=4 gives done 5 cycles after start.
- Back-to-back: start held high during the DONE cycle is accepted at the DONE-exit edge. busy rises in the next cycle, giving one result per WIDTH+1 cycles with no IDLE gap.
- busy and done are never high together.
- Reset deassertion: the first start is accepted at the first rising edge with rst=0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=4, unsigned, a=4'hF, b=4'hF, one-cycle start -> done exactly 5 cycles later, product=8'hE1 (225); busy high for 4 cycles.
- WIDTH=4, signed:
  - a=4'h8 (-8), b=4'h7 -> product=8'hC8 (-56).
  - a=4'h8, b=4'h8 -> product=8'h40 (64).
  - a=4'hF, b=4'hF -> product=8'h01.
- WIDTH=4, exhaustive sweep of all 256 a/b pairs in both modes, start re-asserted during each DONE cycle -> every product matches a*b (signed/unsigned reference); one done per 5 cycles; no idle gap.
- Start pulsed with a=3, b=5 while busy from a prior 2*6 operation -> first result 8'h0C unaffected; no second done; product stays 8'h0C.
- rst asserted asynchronously mid-CALC (cycle 2 of 4) -> busy, done and product are 0 immediately; no done pulse; the next start with 9*9 unsigned gives 8'h51 after 5 cycles.
- WIDTH=8 instance, unsigned 8'hFF*8'hFF -> 16'hFE01 after 9 cycles; signed 8'h80*8'h01 -> 16'hFF80.

Source files
------------

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Sequential shift-add multiplier with optional two's-complement operation.
// One operand bit is consumed per CALC cycle, so a multiplication takes
// WIDTH+1 cycles from the accepting edge to the visible done pulse. The
// operation runs on magnitudes, and the sign is applied once at the end.
//
// Parameters:
//   WIDTH        operand width in bits (2..32)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset; aborts any operation
//   start        request, accepted only in IDLE or DONE
//   signed_mode  1 = two's-complement operands/product, sampled with start
//   a            multiplicand, sampled with start
//   b            multiplier, sampled with start
//   busy         high while a multiplication is in progress
//   done         one-cycle pulse, product valid
//   product      2*WIDTH-bit result, held until the next result is written
// ---------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic               sign_flag;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               accept;
    logic               last_iter;

    // A new operation is taken only when the unit is idle or just finishing,
    // so a start pulse during CALC never disturbs the running operation.
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_iter = (state == CALC) && (count == CW'(WIDTH - 1));

    // Magnitudes are formed in WIDTH-bit unsigned form; the most negative
    // value negates to 2^(WIDTH-1), which is still representable unsigned.
    assign abs_a = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign abs_b = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // The accumulator value after this cycle's partial product; used both
    // for the accumulator update and, on the last iteration, for the result.
    assign acc_sum = mplier[0] ? (acc + mcand) : acc;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE waits for start, CALC runs WIDTH iterations,
    // DONE either chains straight into the next operation or returns idle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                if (count == CW'(WIDTH - 1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operands and sign are captured on accept, then each CALC
    // cycle adds the shifted multiplicand when the multiplier LSB is set.
    // The product register is written only on the transition into DONE,
    // so the previous result stays readable while a new one is computed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            sign_flag <= 1'b0;
            product   <= '0;
        end else if (accept) begin
            count     <= '0;
            mcand     <= {{WIDTH{1'b0}}, abs_a};
            mplier    <= abs_b;
            acc       <= '0;
            sign_flag <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (state == CALC) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (last_iter) begin
                product <= sign_flag ? (~acc_sum + 1'b1) : acc_sum;
            end
        end
    end

    // Status outputs are registered copies of the state, one cycle behind.
    // This places busy over the WIDTH cycles following the accepting edge
    // and the done pulse in the cycle after, and guarantees they never
    // overlap even when operations are chained back to back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state == CALC);
            done <= (state == DONE);
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
//
// Directed bench for seq_multiplier: a WIDTH=4 instance for the bulk of the
// scenarios and a WIDTH=8 instance for the wide-operand cases. Both share
// the clock and reset.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

    logic        clk;
    logic        rst;

    logic        start;
    logic        signed_mode;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  product;

    logic        start8;
    logic        signed_mode8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int checks;
    int errors;

    seq_multiplier #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .signed_mode (signed_mode8),
        .a           (a8),
        .b           (b8),
        .busy        (busy8),
        .done        (done8),
        .product     (product8)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Arithmetic reference for the 4-bit sweep.
    function automatic logic [7:0] ref_mul4(input logic sm, input logic [3:0] x, input logic [3:0] y);
        int xi;
        int yi;
        int p;
        xi = sm ? int'($signed(x)) : int'(x);
        yi = sm ? int'($signed(y)) : int'(y);
        p  = xi * yi;
        return p[7:0];
    endfunction

    // Pulses start for one cycle on the 4-bit unit and waits (bounded) for
    // done; reports cycles from the accepting edge and cycles busy was high.
    task automatic run_op(input logic sm, input logic [3:0] x, input logic [3:0] y,
                          output int lat, output int busy_cycles);
        @(negedge clk);
        signed_mode = sm;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy === 1'b1) busy_cycles++;
        end
    endtask

    task automatic run_op8(input logic sm, input logic [7:0] x, input logic [7:0] y,
                           output int lat);
        @(negedge clk);
        signed_mode8 = sm;
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (product !== 8'h00)  begin errors++; $display("[TB] FAIL reset_product got=%h exp=00", product); end
        checks++; if (busy8 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy8 got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0)     begin errors++; $display("[TB] FAIL reset_done8 got=%b exp=0", done8); end
        checks++; if (product8 !== 16'h0) begin errors++; $display("[TB] FAIL reset_product8 got=%h exp=0000", product8); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned_max();
        int lat;
        int bc;
        run_op(1'b0, 4'hF, 4'hF, lat, bc);
        checks++; if (lat != 5)          begin errors++; $display("[TB] FAIL umax_latency got=%0d exp=5", lat); end
        checks++; if (bc != 4)           begin errors++; $display("[TB] FAIL umax_busy_cycles got=%0d exp=4", bc); end
        checks++; if (product !== 8'hE1) begin errors++; $display("[TB] FAIL umax_product got=%h exp=e1", product); end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL umax_done_width got=%b exp=0", done); end
    endtask

    task automatic test_signed();
        int lat;
        int bc;
        run_op(1'b1, 4'h8, 4'h7, lat, bc);
        checks++; if (lat != 5)          begin errors++; $display("[TB] FAIL s_m8x7_latency got=%0d exp=5", lat); end
        checks++; if (product !== 8'hC8) begin errors++; $display("[TB] FAIL s_m8x7 got=%h exp=c8", product); end
        run_op(1'b1, 4'h8, 4'h8, lat, bc);
        checks++; if (lat != 5)          begin errors++; $display("[TB] FAIL s_m8xm8_latency got=%0d exp=5", lat); end
        checks++; if (product !== 8'h40) begin errors++; $display("[TB] FAIL s_m8xm8 got=%h exp=40", product); end
        run_op(1'b1, 4'hF, 4'hF, lat, bc);
        checks++; if (lat != 5)          begin errors++; $display("[TB] FAIL s_m1xm1_latency got=%0d exp=5", lat); end
        checks++; if (product !== 8'h01) begin errors++; $display("[TB] FAIL s_m1xm1 got=%h exp=01", product); end
    endtask

    // Full 4x4 sweep in both modes with start held high, so each operation
    // is accepted on the edge where the previous done pulse appears.
    task automatic test_back_to_back();
        logic [8:0] cur;
        logic [8:0] nxt;
        logic [7:0] expected;
        int         bad;
        @(negedge clk);
        signed_mode = 1'b0;
        a = 4'h0;
        b = 4'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 512; i++) begin
            cur = i[8:0];
            expected = ref_mul4(cur[8], cur[7:4], cur[3:0]);
            if (i < 511) begin
                nxt = cur + 9'd1;
                signed_mode = nxt[8];
                a = nxt[7:4];
                b = nxt[3:0];
            end else begin
                start = 1'b0;
            end
            bad = 0;
            for (int j = 0; j < 4; j++) begin
                @(posedge clk);
                #1;
                if (busy !== 1'b1 || done !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL b2b_busy_window vec=%0d bad_cycles=%0d exp=0", i, bad);
            end
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_done vec=%0d done=%b busy=%b exp done=1 busy=0", i, done, busy);
            end
            checks++;
            if (product !== expected) begin
                errors++;
                $display("[TB] FAIL b2b_product vec=%0d sm=%b a=%h b=%h got=%h exp=%h",
                         i, cur[8], cur[7:4], cur[3:0], product, expected);
            end
        end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_return_idle done=%b busy=%b exp=0/0", done, busy); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        int extra_done;
        logic [7:0] held;
        @(negedge clk);
        signed_mode = 1'b0;
        a = 4'd2;
        b = 4'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        @(posedge clk);
        #1;
        lat++;
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        a = 4'd0;
        b = 4'd0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++; if (lat != 5)          begin errors++; $display("[TB] FAIL busy_ignore_latency got=%0d exp=5", lat); end
        checks++; if (product !== 8'h0C) begin errors++; $display("[TB] FAIL busy_ignore_product got=%h exp=0c", product); end
        extra_done = 0;
        held = product;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra_done++;
            if (product !== 8'h0C) held = product;
        end
        checks++; if (extra_done != 0)   begin errors++; $display("[TB] FAIL busy_ignore_second_done got=%0d exp=0", extra_done); end
        checks++; if (held !== 8'h0C)    begin errors++; $display("[TB] FAIL busy_ignore_hold got=%h exp=0c", held); end
    endtask

    task automatic test_async_reset();
        int lat;
        int bc;
        int stray_done;
        @(negedge clk);
        signed_mode = 1'b0;
        a = 4'd7;
        b = 4'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("[TB] FAIL arst_done got=%b exp=0", done); end
        checks++; if (product !== 8'h00) begin errors++; $display("[TB] FAIL arst_product got=%h exp=00", product); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        stray_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) stray_done++;
        end
        checks++; if (stray_done != 0)   begin errors++; $display("[TB] FAIL arst_no_done got=%0d exp=0", stray_done); end
        run_op(1'b0, 4'd9, 4'd9, lat, bc);
        checks++; if (lat != 5)          begin errors++; $display("[TB] FAIL arst_next_latency got=%0d exp=5", lat); end
        checks++; if (product !== 8'h51) begin errors++; $display("[TB] FAIL arst_next_product got=%h exp=51", product); end
    endtask

    task automatic test_width8();
        int lat;
        run_op8(1'b0, 8'hFF, 8'hFF, lat);
        checks++; if (lat != 9)              begin errors++; $display("[TB] FAIL w8_umax_latency got=%0d exp=9", lat); end
        checks++; if (product8 !== 16'hFE01) begin errors++; $display("[TB] FAIL w8_umax got=%h exp=fe01", product8); end
        run_op8(1'b1, 8'h80, 8'h01, lat);
        checks++; if (lat != 9)              begin errors++; $display("[TB] FAIL w8_signed_latency got=%0d exp=9", lat); end
        checks++; if (product8 !== 16'hFF80) begin errors++; $display("[TB] FAIL w8_signed got=%h exp=ff80", product8); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        signed_mode  = 1'b0;
        a            = '0;
        b            = '0;
        start8       = 1'b0;
        signed_mode8 = 1'b0;
        a8           = '0;
        b8           = '0;

        $display("[TB] seq_multiplier directed tests");
        test_reset();
        test_unsigned_max();
        test_signed();
        test_back_to_back();
        test_start_while_busy();
        test_async_reset();
        test_width8();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
